// File: rtl/pipeline_pkg.sv
// Shared defaults for the receive pipeline and the FIFO operation encoding
// used by the storage sub-module.
package pipeline_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned DEPTH_DEF       = 8;
  localparam int unsigned COUNT_WIDTH_DEF = 16;
  localparam int unsigned PIPE_STAGES_DEF = 3;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: storage, wrapping pointers, fill level and a
// registered valid flag. The caller guarantees push/pop legality.
module sync_fifo_fwft
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic                  r_valid;
  logic [AW:0]           w_level_nxt;
  fifo_op_e              w_op;

  assign w_op = fifo_op_e'({i_push, i_pop});

  always_comb begin
    w_level_nxt = r_level;
    case (w_op)
      FIFO_PUSH: w_level_nxt = r_level + (AW+1)'(1);
      FIFO_POP:  w_level_nxt = r_level - (AW+1)'(1);
      default:   w_level_nxt = r_level;
    endcase
  end

  // Storage is deliberately left unreset; valid gates the stale contents.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = r_valid;
  assign o_level = r_level;

endmodule

// File: rtl/pipeline_receiver.sv
// Receives words from a non-backpressured upstream into a FWFT FIFO, tracking
// accepted words and flagging drops when the FIFO is full.
module pipeline_receiver
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     clr_overflow,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [COUNT_WIDTH-1:0]   rx_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic                   w_valid;
  logic [AW:0]            w_level;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   r_overflow;
  logic [COUNT_WIDTH-1:0] r_rx_count;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_pop  = w_valid & out_ready;
  assign w_push = in_valid & ((w_level != FULL_LEVEL) | w_pop);
  assign w_drop = in_valid & ~w_push;

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_data),
    .o_data  (out_data),
    .o_valid (w_valid),
    .o_level (w_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_rx_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
      if (w_push && (r_rx_count != '1)) begin
        r_rx_count <= r_rx_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign out_valid  = w_valid;
  assign fill_level = w_level;
  assign overflow   = r_overflow;
  assign rx_count   = r_rx_count;

endmodule

// File: tb/tb_pipeline_receiver.sv
// Directed and random stimulus against a queue-based reference model of the
// receiver; a narrow-counter instance shares the inputs to exercise saturation.
module tb_pipeline_receiver;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       clr_overflow;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overflow;
  logic [3:0] fill_level;
  logic [15:0] rx_count;
  logic [7:0] s_out_data;
  logic       s_out_valid;
  logic       s_overflow;
  logic [3:0] s_fill_level;
  logic [2:0] s_rx_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  bit         m_ovf;
  int         m_cnt;

  pipeline_receiver dut (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid),
    .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
    .clr_overflow (clr_overflow), .overflow (overflow),
    .fill_level (fill_level), .rx_count (rx_count)
  );

  pipeline_receiver #(.COUNT_WIDTH(3)) dut_small (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid),
    .out_data (s_out_data), .out_valid (s_out_valid), .out_ready (out_ready),
    .clr_overflow (clr_overflow), .overflow (s_overflow),
    .fill_level (s_fill_level), .rx_count (s_rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("fill_level", 32'(fill_level), 32'(mq.size()));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rx_count", 32'(rx_count), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("rx_count_sat", 32'(s_rx_count), 32'((m_cnt > 7) ? 7 : m_cnt));
  endtask

  // Reference behaviour at one rising edge, from the current input values.
  task automatic model_edge();
    bit pop, push;
    pop  = (mq.size() != 0) && out_ready;
    push = in_valid && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(in_data);
      m_cnt++;
    end
    if (in_valid && !push) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    in_valid = v; in_data = d; out_ready = rdy; clr_overflow = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clr_overflow = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    rst = 1'b0;

    // Single word with downstream ready: visible for exactly one cycle.
    step(1'b1, 8'hDB, 1'b1, 1'b0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hDB);
    chk("single_count", 32'(rx_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_gone", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Exactly-full burst, then ordered drain.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h01 + i), 1'b0, 1'b0);
    chk("burst8_level", 32'(fill_level), 32'd8);
    chk("burst8_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("burst8_order", 32'(out_data), 32'(8'h01 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Over-full burst drops the last two words.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("burst10_ovf", 32'(overflow), 32'd1);
    chk("burst10_count", 32'(rx_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("burst10_order", 32'(out_data), 32'(8'h10 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("burst10_empty", 32'(out_valid), 32'd0);

    // Clear coinciding with a drop keeps the flag; a clean clear drops it.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'h3F, 1'b0, 1'b1);
    chk("clr_with_drop", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_clean", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop: no drop.
    step(1'b1, 8'h40, 1'b1, 1'b0);
    chk("full_pushpop_level", 32'(fill_level), 32'd8);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    chk("full_pushpop_head", 32'(out_data), 32'h31);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset with words stored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(fill_level), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("post_rst_head", 32'(out_data), 32'hAA);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 10));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
